ex_muldiv_unit: RTL
===================

# ex_muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the ID/EX pipeline register. It takes the decoded M-extension operation, the forwarded rs1/rs2 operand values and the rd address from the EX side of ID/EX. It runs a 32-step shift-add or restoring-divide sequence, and holds the front of the pipeline through a stall output until the result is ready for EX/MEM.

## Interface
Parameters:
- XLEN, 32, operand/result width; only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset; single clock domain
- start  in  1  EX holds a valid M-extension instruction
- op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- opa  in  32  rs1 value after forwarding
- opb  in  32  rs2 value after forwarding
- rd_in  in  5  destination register
- flush  in  1  kill the in-flight operation (branch redirect/trap)
- stall  out  1  freeze PC, IF/ID and ID/EX (drives their enable low)
- done  out  1  result valid this cycle
- result  out  32  result, valid when done=1
- rd_out  out  5  latched rd, valid when done=1

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - start=1 with a normal case: latch operand magnitudes, sign flags, op and rd; clear step counter; go to CALC.
  - start=1 with a special case: load the fixed result; go directly to DONE.
- CALC: one iteration per cycle; counter 0..31; after step 31 apply sign correction, register result, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. start is ignored in DONE, because the same instruction is still in EX.
- Multiply: unsigned 32x32 shift-add into a 64-bit accumulator on magnitudes.
  - Negate the product if the operand signs differ.
  - MUL returns the low word; MULH/MULHSU/MULHU return the high word.
  - Signedness: MULH both operands signed; MULHSU only opa signed; MULHU neither.
- Divide: restoring division on magnitudes, 32-bit quotient and 33-bit partial remainder.
  - Quotient sign = sa^sb; remainder sign = sa (DIV/REM only).
- Special cases (single-cycle path):
  - Divisor 0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return opa.
  - Signed overflow (opa=0x80000000, opb=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- flush=1 in any state: go to IDLE next edge; done is not asserted for the killed op. flush has priority over start.
- All outputs are driven only from registered state plus the combinational stall term.

## Timing
- Reset (async, reset_n=0): state=IDLE, counter=0, done=0, result=0, rd_out=0, stall=0. Takes effect immediately, including mid-CALC.
- stall = (state==IDLE & start & !flush) | (state==CALC). stall is combinational on start so ID/EX holds in the accept cycle.
- Normal op accepted in cycle T:
  - CALC occupies T+1..T+32.
  - DONE in T+33 with done=1 and stall=0, so the pipeline advances and EX/MEM captures result.
  - Latency is 33 cycles; stall is high T..T+32.
- Special case accepted in T: done=1 in T+1; stall high only in T.
- Back-to-back ops: the earliest next accept is T+34, when the new instruction reaches EX.
- Arithmetic is modulo 2^32 on outputs; no exceptions are raised.

## Structure
- A shared package (riscv_pkg) holds the muldiv_op_t enum for the funct3 encodings, the XLEN constant, and the muldiv_state_t enum.
- One sub-module: muldiv_datapath, the shift-add/restoring-divide step logic plus sign correction. The FSM, counter and special-case detection stay in ex_muldiv_unit.

## Test plan
- MUL 7 x 0xFFFFFFFD (start in T) -> stall high T..T+32, done at T+33, result 0xFFFFFFEB, rd_out=rd_in.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM of the same operands -> 0xFFFFFFFF. DIVU 100 / 7 -> 14. REMU of the same operands -> 2.
- DIVU 5 / 0 -> done at T+1, result 0xFFFFFFFF. REM 5 / 0 -> 5. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 at T+1. REM of the same operands -> 0.
- flush at T+10 during CALC -> IDLE at T+11, stall low, no done pulse. A new start at T+12 completes normally at T+45.
- reset_n pulled low at T+20 mid-CALC -> all outputs zero immediately; after release, start with start held high in DONE produces exactly one done pulse per accepted op.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32M execute-stage multiply/divide unit:
// datapath width, funct3 operation encodings, FSM states and small
// decode helpers for operand signedness.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_t;

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM
  function automatic logic op_signed_a(input muldiv_op_t o);
    return (o == OP_MULH) || (o == OP_MULHSU) || (o == OP_DIV) || (o == OP_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM
  function automatic logic op_signed_b(input muldiv_op_t o);
    return (o == OP_MULH) || (o == OP_DIV) || (o == OP_REM);
  endfunction

  // funct3[2] separates the divide group from the multiply group
  function automatic logic op_is_div(input muldiv_op_t o);
    return o[2];
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative step logic: one shift-add multiply bit or one restoring-divide
// bit per enabled cycle, on operand magnitudes. The multiply keeps the
// running high word in acc_hi and the shifting multiplier/low product in
// acc_lo; the divide keeps the partial remainder in acc_hi and shifts the
// dividend out of / quotient into acc_lo. result_next is the sign-corrected
// result as it will be after the current step, so the controller can
// register it on the final step edge.
module muldiv_datapath #(
  parameter int XLEN = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load,
  input  logic                   step,
  input  riscv_pkg::muldiv_op_t  op,
  input  logic                   sign_a,
  input  logic                   sign_b,
  input  logic [XLEN-1:0]        mag_a,
  input  logic [XLEN-1:0]        mag_b,
  output logic [XLEN-1:0]        result_next
);
  import riscv_pkg::*;

  logic [XLEN-1:0]   acc_hi;
  logic [XLEN-1:0]   acc_lo;
  logic [XLEN-1:0]   operand_b;

  logic [XLEN:0]     sum;
  logic [XLEN:0]     shifted;
  logic [XLEN:0]     trial;
  logic [XLEN-1:0]   hi_step;
  logic [XLEN-1:0]   lo_step;

  logic [2*XLEN-1:0] product;
  logic [2*XLEN-1:0] product_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;

  // One iteration: shift-add for multiply, trial-subtract for divide
  always_comb begin
    sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_b} : '0);
    shifted = {acc_hi, acc_lo[XLEN-1]};
    trial   = shifted - {1'b0, operand_b};
    hi_step = acc_hi;
    lo_step = acc_lo;
    if (op_is_div(op)) begin
      // A clear borrow bit means the divisor fit; the remainder then
      // always fits in XLEN bits, as does the shifted value on failure.
      if (!trial[XLEN]) begin
        hi_step = trial[XLEN-1:0];
        lo_step = {acc_lo[XLEN-2:0], 1'b1};
      end else begin
        hi_step = shifted[XLEN-1:0];
        lo_step = {acc_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_step = sum[XLEN:1];
      lo_step = {sum[0], acc_lo[XLEN-1:1]};
    end
  end

  // Accumulator registers: load magnitudes on accept, advance on each step
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_hi    <= '0;
      acc_lo    <= '0;
      operand_b <= '0;
    end else if (load) begin
      acc_hi    <= '0;
      acc_lo    <= mag_a;
      operand_b <= mag_b;
    end else if (step) begin
      acc_hi    <= hi_step;
      acc_lo    <= lo_step;
    end
  end

  // Sign correction and result word selection on the post-step state
  always_comb begin
    product     = {hi_step, lo_step};
    product_fix = (sign_a ^ sign_b) ? (~product + 1'b1) : product;
    quot_fix    = (sign_a ^ sign_b) ? (~lo_step + 1'b1) : lo_step;
    rem_fix     = sign_a ? (~hi_step + 1'b1) : hi_step;
    result_next = '0;
    case (op)
      OP_MUL:                       result_next = product_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result_next = product_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              result_next = quot_fix;
      OP_REM, OP_REMU:              result_next = rem_fix;
      default:                      result_next = '0;
    endcase
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// RV32M multiply/divide unit sitting in EX. Accepts an M-extension op from
// ID/EX, stalls the front of the pipeline for 33 cycles while the datapath
// iterates, and presents result/rd for one cycle in DONE. Divide-by-zero and
// signed overflow bypass the iteration and complete in one cycle.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);
  import riscv_pkg::*;

  muldiv_state_t   state_reg;
  muldiv_state_t   state_next;
  logic [4:0]      count_reg;
  muldiv_op_t      op_reg;
  logic            sign_a_reg;
  logic            sign_b_reg;
  logic [XLEN-1:0] result_reg;
  logic [4:0]      rd_reg;

  muldiv_op_t      op_in;
  logic            sign_a_in;
  logic            sign_b_in;
  logic [XLEN-1:0] mag_a_in;
  logic [XLEN-1:0] mag_b_in;
  logic            div_zero;
  logic            div_ovf;
  logic            special;
  logic [XLEN-1:0] special_value;
  logic            accept;
  logic            last_step;
  logic [XLEN-1:0] result_next;

  // Decode the incoming op, form magnitudes and spot the single-cycle cases
  always_comb begin
    op_in     = muldiv_op_t'(op);
    sign_a_in = opa[XLEN-1] & op_signed_a(op_in);
    sign_b_in = opb[XLEN-1] & op_signed_b(op_in);
    mag_a_in  = sign_a_in ? (~opa + 1'b1) : opa;
    mag_b_in  = sign_b_in ? (~opb + 1'b1) : opb;
    div_zero  = op_is_div(op_in) && (opb == '0);
    div_ovf   = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                (opa == {1'b1, {(XLEN-1){1'b0}}}) && (opb == '1);
    special   = div_zero || div_ovf;
    special_value = '0;
    if (div_zero) begin
      special_value = ((op_in == OP_DIV) || (op_in == OP_DIVU)) ? '1 : opa;
    end else if (div_ovf) begin
      special_value = (op_in == OP_DIV) ? {1'b1, {(XLEN-1){1'b0}}} : '0;
    end
    accept    = (state_reg == ST_IDLE) && start && !flush;
    last_step = (state_reg == ST_CALC) && (count_reg == 5'd31);
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // FSM next-state logic; flush wins over everything, start is ignored in DONE
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: if (start) state_next = special ? ST_DONE : ST_CALC;
        ST_CALC: if (count_reg == 5'd31) state_next = ST_DONE;
        ST_DONE: state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: stall holds ID/EX in the accept cycle and throughout CALC
  always_comb begin
    stall  = accept || (state_reg == ST_CALC);
    done   = (state_reg == ST_DONE);
    result = result_reg;
    rd_out = rd_reg;
  end

  // Step counter: cleared on accept, advanced once per CALC cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                   count_reg <= '0;
    else if (accept)                count_reg <= '0;
    else if (state_reg == ST_CALC)  count_reg <= count_reg + 5'd1;
  end

  // Latch op, operand signs and destination when an instruction is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_reg     <= OP_MUL;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      rd_reg     <= '0;
    end else if (accept) begin
      op_reg     <= op_in;
      sign_a_reg <= sign_a_in;
      sign_b_reg <= sign_b_in;
      rd_reg     <= rd_in;
    end
  end

  // Result register: fixed value on the fast path, datapath value on step 31
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  result_reg <= '0;
    else if (accept && special)    result_reg <= special_value;
    else if (last_step && !flush)  result_reg <= result_next;
  end

  muldiv_datapath #(
    .XLEN (XLEN)
  ) u_datapath (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (accept && !special),
    .step        (state_reg == ST_CALC),
    .op          (op_reg),
    .sign_a      (sign_a_reg),
    .sign_b      (sign_b_reg),
    .mag_a       (mag_a_in),
    .mag_b       (mag_b_in),
    .result_next (result_next)
  );

endmodule
